// File: rtl/que_arbiter_rr.sv
// que_arbiter_rr: snapshots pending flags and priority levels, then grants one port at a time
// over valid/ready; highest level first, round-robin (or lowest index) within a level.
module que_arbiter_rr #(
   parameter int PORTNUM = 16,
   parameter int PRIOR   = 8,
   parameter int RR_EN   = 1,
   localparam int PW     = $clog2(PORTNUM),
   localparam int QW     = $clog2(PRIOR)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [PORTNUM-1:0]    i_pending,
   input  logic [PORTNUM*QW-1:0] i_prior,
   input  logic                  i_update,
   input  logic                  i_port_rdy,
   output logic [PW-1:0]         o_port,
   output logic [QW-1:0]         o_prior,
   output logic                  o_port_vld,
   output logic                  o_empty,
   output logic                  o_done
);

   localparam logic [1:0]    ST_IDLE   = 2'd0;
   localparam logic [1:0]    ST_ARB    = 2'd1;
   localparam logic [1:0]    ST_GRANT  = 2'd2;
   localparam logic [QW-1:0] LVL_MAX   = QW'(PRIOR - 1);
   localparam logic [PW-1:0] PORT_LAST = PW'(PORTNUM - 1);

   logic [PORTNUM-1:0] pend_r;
   logic [QW-1:0]      lvl_r     [PORTNUM];
   logic [PW-1:0]      rr_ptr_r  [PRIOR];
   logic [1:0]         state_r;
   logic [PW-1:0]      port_r;
   logic [QW-1:0]      prior_r;
   logic               vld_r;
   logic               empty_r;
   logic               done_r;

   logic [QW-1:0]      lvl_in_s  [PORTNUM];
   logic [QW-1:0]      top_lvl_s;
   logic [PORTNUM-1:0] at_lvl_s;
   logic [PORTNUM-1:0] pend_clr_s;
   logic [PW-1:0]      win_s;
   logic               accept_s;

   // Clamp incoming priority levels that exceed the highest legal level.
   always_comb begin
      for (int p = 0; p < PORTNUM; p++) begin
         if (i_prior[p*QW +: QW] > LVL_MAX) begin
            lvl_in_s[p] = LVL_MAX;
         end else begin
            lvl_in_s[p] = i_prior[p*QW +: QW];
         end
      end
   end

   // Find the most urgent level among pending ports.
   always_comb begin
      top_lvl_s = {QW{1'b0}};
      for (int p = 0; p < PORTNUM; p++) begin
         if (pend_r[p] && (lvl_r[p] > top_lvl_s)) begin
            top_lvl_s = lvl_r[p];
         end else begin
            top_lvl_s = top_lvl_s;
         end
      end
   end

   // Mark candidates at the winning level and the snapshot after clearing the granted port.
   always_comb begin
      at_lvl_s   = {PORTNUM{1'b0}};
      pend_clr_s = pend_r;
      for (int p = 0; p < PORTNUM; p++) begin
         at_lvl_s[p] = pend_r[p] && (lvl_r[p] == top_lvl_s);
      end
      pend_clr_s[port_r] = 1'b0;
   end

   generate
      if (RR_EN != 0) begin : g_rr
         logic [PW-1:0] cand_s;
         logic          found_s;

         // Circular search starting just after the last granted port of this level.
         always_comb begin
            cand_s  = rr_ptr_r[top_lvl_s];
            found_s = 1'b0;
            win_s   = {PW{1'b0}};
            for (int k = 0; k < PORTNUM; k++) begin
               if (cand_s == PORT_LAST) begin
                  cand_s = {PW{1'b0}};
               end else begin
                  cand_s = cand_s + PW'(1);
               end
               if (!found_s && at_lvl_s[cand_s]) begin
                  win_s   = cand_s;
                  found_s = 1'b1;
               end else begin
                  win_s   = win_s;
               end
            end
         end
      end else begin : g_fixed
         // Lowest index at the winning level.
         always_comb begin
            win_s = {PW{1'b0}};
            for (int p = PORTNUM - 1; p >= 0; p--) begin
               if (at_lvl_s[p]) begin
                  win_s = PW'(p);
               end else begin
                  win_s = win_s;
               end
            end
         end
      end
   endgenerate

   assign accept_s = (state_r == ST_GRANT) && vld_r && i_port_rdy;

   // Snapshot, round-robin pointers, FSM and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_r  <= {PORTNUM{1'b0}};
         for (int p = 0; p < PORTNUM; p++) begin
            lvl_r[p] <= {QW{1'b0}};
         end
         for (int l = 0; l < PRIOR; l++) begin
            rr_ptr_r[l] <= PORT_LAST;
         end
         state_r <= ST_IDLE;
         port_r  <= {PW{1'b0}};
         prior_r <= {QW{1'b0}};
         vld_r   <= 1'b0;
         empty_r <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (i_update) begin
            // A new snapshot overrides any clear from a same-edge acceptance.
            pend_r  <= i_pending;
            lvl_r   <= lvl_in_s;
            vld_r   <= 1'b0;
            empty_r <= ~|i_pending;
            state_r <= (|i_pending) ? ST_ARB : ST_IDLE;
            if (accept_s) begin
               rr_ptr_r[prior_r] <= port_r;
            end
         end else begin
            case (state_r)
               ST_IDLE: begin
                  vld_r <= 1'b0;
               end
               ST_ARB: begin
                  if (|pend_r) begin
                     port_r  <= win_s;
                     prior_r <= top_lvl_s;
                     vld_r   <= 1'b1;
                     state_r <= ST_GRANT;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_GRANT: begin
                  if (accept_s) begin
                     pend_r            <= pend_clr_s;
                     rr_ptr_r[prior_r] <= port_r;
                     vld_r             <= 1'b0;
                     empty_r           <= ~|pend_clr_s;
                     if (|pend_clr_s) begin
                        state_r <= ST_ARB;
                     end else begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  vld_r   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_port     = port_r;
   assign o_prior    = prior_r;
   assign o_port_vld = vld_r;
   assign o_empty    = empty_r;
   assign o_done     = done_r;

endmodule

// File: tb/tb_que_arbiter_rr.sv
// tb_que_arbiter_rr: three arbiter configurations checked cycle by cycle against a
// behavioural model, plus directed checks of the documented scenarios.
module tb_que_arbiter_rr;

   logic        clk;
   logic        rst;
   logic        upd;
   logic        rdy;
   logic [15:0] pend_in;
   logic [2:0]  pr [16];
   logic [47:0] prior16;
   logic [9:0]  prior5;

   logic [3:0]  port_a, port_b;
   logic [2:0]  prio_a, prio_b;
   logic        vld_a, vld_b, empty_a, empty_b, done_a, done_b;
   logic [2:0]  port_c;
   logic [1:0]  prio_c;
   logic        vld_c, empty_c, done_c;

   int n_vec = 0;
   int n_err = 0;

   // configuration of the three instances: ports, levels, level width, round-robin
   int cfg_n  [3] = '{16, 16, 5};
   int cfg_p  [3] = '{8, 8, 3};
   int cfg_q  [3] = '{3, 3, 2};
   int cfg_rr [3] = '{1, 0, 1};

   // model state
   int m_pend [3][16];
   int m_lvl  [3][16];
   int m_rr   [3][8];
   int m_st   [3];   // 0 idle, 1 choosing, 2 offering
   int m_port [3];
   int m_prio [3];
   int m_vld  [3];
   int m_empty[3];
   int m_done [3];

   always_comb begin
      prior16 = 48'd0;
      prior5  = 10'd0;
      for (int p = 0; p < 16; p++) prior16[p*3 +: 3] = pr[p];
      for (int p = 0; p < 5; p++)  prior5[p*2 +: 2]  = pr[p][1:0];
   end

   que_arbiter_rr #(.PORTNUM(16), .PRIOR(8), .RR_EN(1)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_pending(pend_in), .i_prior(prior16),
      .i_update(upd), .i_port_rdy(rdy), .o_port(port_a), .o_prior(prio_a),
      .o_port_vld(vld_a), .o_empty(empty_a), .o_done(done_a));

   que_arbiter_rr #(.PORTNUM(16), .PRIOR(8), .RR_EN(0)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_pending(pend_in), .i_prior(prior16),
      .i_update(upd), .i_port_rdy(rdy), .o_port(port_b), .o_prior(prio_b),
      .o_port_vld(vld_b), .o_empty(empty_b), .o_done(done_b));

   que_arbiter_rr #(.PORTNUM(5), .PRIOR(3), .RR_EN(1)) u_dut_c (
      .i_clk(clk), .i_rst(rst), .i_pending(pend_in[4:0]), .i_prior(prior5),
      .i_update(upd), .i_port_rdy(rdy), .o_port(port_c), .o_prior(prio_c),
      .o_port_vld(vld_c), .o_empty(empty_c), .o_done(done_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_vec++;
      if (obs != exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int m_count(input int k);
      int c = 0;
      for (int p = 0; p < cfg_n[k]; p++) c += m_pend[k][p];
      return c;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 16; p++) begin
            m_pend[k][p] = 0;
            m_lvl[k][p]  = 0;
         end
         for (int l = 0; l < 8; l++) m_rr[k][l] = cfg_n[k] - 1;
         m_st[k] = 0; m_port[k] = 0; m_prio[k] = 0;
         m_vld[k] = 0; m_empty[k] = 1; m_done[k] = 0;
      end
   endtask

   // one clock edge of the reference behaviour for instance k
   task automatic model_step(input int k);
      int acc, lv, win, v, n;
      n   = cfg_n[k];
      acc = (m_st[k] == 2 && m_vld[k] == 1 && rdy == 1'b1) ? 1 : 0;
      m_done[k] = 0;
      if (upd) begin
         if (acc) m_rr[k][m_prio[k]] = m_port[k];
         for (int p = 0; p < n; p++) begin
            m_pend[k][p] = int'(pend_in[p]);
            v = int'(pr[p]) & ((1 << cfg_q[k]) - 1);
            if (v > cfg_p[k] - 1) v = cfg_p[k] - 1;
            m_lvl[k][p] = v;
         end
         m_vld[k] = 0;
         m_st[k]  = (m_count(k) > 0) ? 1 : 0;
      end else if (m_st[k] == 1) begin
         if (m_count(k) > 0) begin
            lv = -1;
            for (int p = 0; p < n; p++)
               if (m_pend[k][p] == 1 && m_lvl[k][p] > lv) lv = m_lvl[k][p];
            win = -1;
            if (cfg_rr[k] == 1) begin
               for (int s = 1; s <= n; s++) begin
                  v = (m_rr[k][lv] + s) % n;
                  if (win < 0 && m_pend[k][v] == 1 && m_lvl[k][v] == lv) win = v;
               end
            end else begin
               for (int p = n - 1; p >= 0; p--)
                  if (m_pend[k][p] == 1 && m_lvl[k][p] == lv) win = p;
            end
            m_port[k] = win; m_prio[k] = lv; m_vld[k] = 1; m_st[k] = 2;
         end else begin
            m_st[k] = 0;
         end
      end else if (m_st[k] == 2 && acc == 1) begin
         m_pend[k][m_port[k]] = 0;
         m_rr[k][m_prio[k]]   = m_port[k];
         m_vld[k] = 0;
         if (m_count(k) > 0) m_st[k] = 1;
         else begin
            m_st[k]   = 0;
            m_done[k] = 1;
         end
      end
      m_empty[k] = (m_count(k) == 0) ? 1 : 0;
   endtask

   task automatic check_all();
      int op, oq, ov, oe, od;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            op = int'(port_a); oq = int'(prio_a); ov = int'(vld_a); oe = int'(empty_a); od = int'(done_a);
         end else if (k == 1) begin
            op = int'(port_b); oq = int'(prio_b); ov = int'(vld_b); oe = int'(empty_b); od = int'(done_b);
         end else begin
            op = int'(port_c); oq = int'(prio_c); ov = int'(vld_c); oe = int'(empty_c); od = int'(done_c);
         end
         chk($sformatf("i%0d_port", k),  op, m_port[k]);
         chk($sformatf("i%0d_prior", k), oq, m_prio[k]);
         chk($sformatf("i%0d_vld", k),   ov, m_vld[k]);
         chk($sformatf("i%0d_empty", k), oe, m_empty[k]);
         chk($sformatf("i%0d_done", k),  od, m_done[k]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else for (int k = 0; k < 3; k++) model_step(k);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; upd = 1'b0; rdy = 1'b0; pend_in = 16'h0000;
      for (int p = 0; p < 16; p++) pr[p] = 3'd0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_empty", int'(empty_a), 1);
         chk("idle_vld", int'(vld_a), 0);
         chk("idle_done", int'(done_a), 0);
      end

      // levels first, round-robin within level 3
      pr[4] = 3'd1; pr[5] = 3'd3; pr[6] = 3'd3; pr[7] = 3'd0;
      pend_in = 16'h00F0; upd = 1'b1; rdy = 1'b1;
      tick();
      upd = 1'b0;
      chk("t1_vld_n", int'(vld_a), 0);
      chk("t1_empty_n", int'(empty_a), 0);
      tick();
      chk("t1_g1_port", int'(port_a), 5); chk("t1_g1_prio", int'(prio_a), 3); chk("t1_g1_vld", int'(vld_a), 1);
      tick();
      chk("t1_acc_vld", int'(vld_a), 0);
      tick();
      chk("t1_g2_port", int'(port_a), 6); chk("t1_g2_prio", int'(prio_a), 3);
      tick(); tick();
      chk("t1_g3_port", int'(port_a), 4); chk("t1_g3_prio", int'(prio_a), 1);
      tick(); tick();
      chk("t1_g4_port", int'(port_a), 7); chk("t1_g4_prio", int'(prio_a), 0);
      tick();
      chk("t1_done", int'(done_a), 1); chk("t1_empty", int'(empty_a), 1); chk("t1_end_vld", int'(vld_a), 0);
      tick();
      chk("t1_done_pulse", int'(done_a), 0);

      // clamp and wrap on the 5-port instance
      pend_in = 16'h0011; pr[0] = 3'd3; pr[4] = 3'd3; upd = 1'b1; rdy = 1'b0;
      tick();
      upd = 1'b0;
      tick();
      chk("clamp_port", int'(port_c), 0);
      chk("clamp_prior", int'(prio_c), 2);
      rdy = 1'b1;
      repeat (6) tick();
      rdy = 1'b0;

      // round-robin fairness versus fixed order
      do_reset();
      pend_in = 16'h0003; pr[0] = 3'd2; pr[1] = 3'd2; upd = 1'b1;
      tick();
      upd = 1'b0;
      tick();
      chk("fair_first_a", int'(port_a), 0); chk("fair_first_b", int'(port_b), 0);
      rdy = 1'b1;
      tick();
      rdy = 1'b0; upd = 1'b1;
      tick();
      upd = 1'b0;
      tick();
      chk("fair_rr", int'(port_a), 1); chk("fair_fixed", int'(port_b), 0); chk("fair_rr_small", int'(port_c), 1);
      rdy = 1'b1;
      repeat (8) tick();
      rdy = 1'b0;

      // backpressure on port 9
      do_reset();
      pend_in = 16'h0600; pr[9] = 3'd5; pr[10] = 3'd5; upd = 1'b1;
      tick();
      upd = 1'b0;
      tick();
      chk("bp_port", int'(port_a), 9); chk("bp_vld", int'(vld_a), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_port", int'(port_a), 9); chk("bp_hold_vld", int'(vld_a), 1);
      end
      rdy = 1'b1;
      tick();
      chk("bp_acc_vld", int'(vld_a), 0);
      rdy = 1'b0;
      tick();
      chk("bp_next_port", int'(port_a), 10); chk("bp_next_vld", int'(vld_a), 1);
      rdy = 1'b1;
      tick();
      chk("bp_done", int'(done_a), 1);
      rdy = 1'b0;

      // mid-round update withdraws the grant
      pend_in = 16'h0008; pr[3] = 3'd4; upd = 1'b1;
      tick();
      upd = 1'b0;
      tick();
      chk("mid_port", int'(port_a), 3);
      pend_in = 16'h8000; pr[15] = 3'd2; upd = 1'b1;
      tick();
      upd = 1'b0;
      chk("mid_vld", int'(vld_a), 0); chk("mid_done", int'(done_a), 0);
      tick();
      chk("mid_new_port", int'(port_a), 15); chk("mid_new_vld", int'(vld_a), 1);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      tick();

      // acceptance and update at the same edge
      pend_in = 16'h0018; pr[3] = 3'd4; pr[4] = 3'd4; upd = 1'b1;
      tick();
      upd = 1'b0;
      tick();
      chk("au_first", int'(port_a), 3);
      rdy = 1'b1; upd = 1'b1;
      tick();
      rdy = 1'b0; upd = 1'b0;
      chk("au_done", int'(done_a), 0); chk("au_vld", int'(vld_a), 0);
      tick();
      chk("au_rr_ptr", int'(port_a), 4);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      tick();
      chk("au_kept_pending", int'(port_a), 3);
      rdy = 1'b1;
      tick();
      chk("au_final_done", int'(done_a), 1);
      rdy = 1'b0;

      // asynchronous reset while a grant is offered
      pend_in = 16'h0100; pr[8] = 3'd6; upd = 1'b1;
      tick();
      upd = 1'b0;
      tick();
      chk("ar_pre_vld", int'(vld_a), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_vld", int'(vld_a), 0);
      chk("ar_empty", int'(empty_a), 1);
      chk("ar_done", int'(done_a), 0);
      model_reset();
      tick();
      rst = 1'b0;
      tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         upd = ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0;
         if (upd) begin
            pend_in = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom());
            for (int p = 0; p < 16; p++) pr[p] = 3'($urandom_range(0, 7));
         end
         rdy = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
